// File: rtl/issue_scoreboard_ctrl_if.sv
// Decode-to-issue bundle: instruction operands, writeback clear port, flush,
// and the issue decision plus scoreboard/perf visibility back to the pipeline.
interface issue_scoreboard_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic             decode_valid_i;
  logic [4:0]       rs1_adres_i;
  logic             rs1_use_i;
  logic [4:0]       rs2_adres_i;
  logic             rs2_use_i;
  logic [4:0]       rd_adres_i;
  logic             rd_write_i;
  logic             multicycle_i;
  logic [4:0]       writeback_address_i;
  logic             writeback_enable_i;
  logic             flush_i;
  logic             issue_o;
  logic             stall_o;
  logic             mc_busy_o;
  logic [31:0]      pending_o;
  logic [CNT_W-1:0] stall_cycles_o;

  // Handshake: decode offers an instruction with decode_valid_i; it is taken in
  // a cycle where issue_o=1, held while stall_o=1, and dropped when flush_i=1.
  modport slave (
    input  decode_valid_i, rs1_adres_i, rs1_use_i, rs2_adres_i, rs2_use_i,
           rd_adres_i, rd_write_i, multicycle_i, writeback_address_i,
           writeback_enable_i, flush_i,
    output issue_o, stall_o, mc_busy_o, pending_o, stall_cycles_o
  );

  modport master (
    output decode_valid_i, rs1_adres_i, rs1_use_i, rs2_adres_i, rs2_use_i,
           rd_adres_i, rd_write_i, multicycle_i, writeback_address_i,
           writeback_enable_i, flush_i,
    input  issue_o, stall_o, mc_busy_o, pending_o, stall_cycles_o
  );
endinterface

// File: rtl/issue_scoreboard_ctrl.sv
// Issue controller: integer-register scoreboard with RAW/WAW hazard stall,
// mul/div occupancy blocking, and a saturating stall-cycle counter.
module issue_scoreboard_ctrl #(
  parameter int unsigned MC_LATENCY = 4,
  parameter bit          WB_BYPASS  = 1'b1,
  parameter int unsigned CNT_W      = 16
) (
  input logic                   clk_i,
  input logic                   rst_i,
  issue_scoreboard_ctrl_if.slave bus
);
  logic [31:0]      pending_q, pending_d;
  logic [31:0]      clr, set, eff;
  logic [3:0]       mc_cnt_q, mc_cnt_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic             hazard, mc_block, issue, stall;

  always_comb begin
    clr = '0;
    if (bus.writeback_enable_i && bus.writeback_address_i != 5'd0)
      clr[bus.writeback_address_i] = 1'b1;
    eff = WB_BYPASS ? (pending_q & ~clr) : pending_q;
  end

  // eff[0] is always 0 since x0 is never marked, so x0 operands are hazard-free.
  always_comb begin
    hazard   = (bus.rs1_use_i  & eff[bus.rs1_adres_i]) |
               (bus.rs2_use_i  & eff[bus.rs2_adres_i]) |
               (bus.rd_write_i & eff[bus.rd_adres_i]);
    mc_block = bus.multicycle_i && (mc_cnt_q != 4'd0);
    issue    = ~rst_i & bus.decode_valid_i & ~hazard & ~mc_block & ~bus.flush_i;
    stall    = ~rst_i & bus.decode_valid_i & ~issue & ~bus.flush_i;
  end

  always_comb begin
    set = '0;
    if (issue && bus.rd_write_i && bus.rd_adres_i != 5'd0)
      set[bus.rd_adres_i] = 1'b1;
    // Set is applied after clear so a same-cycle re-issue keeps the bit.
    pending_d    = (pending_q & ~clr) | set;
    pending_d[0] = 1'b0;

    mc_cnt_d = mc_cnt_q;
    if (issue && bus.multicycle_i)
      mc_cnt_d = 4'(MC_LATENCY - 1);
    else if (mc_cnt_q != 4'd0)
      mc_cnt_d = mc_cnt_q - 4'd1;

    stall_cycles_d = stall_cycles_q;
    if (stall && !(&stall_cycles_q))
      stall_cycles_d = stall_cycles_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pending_q      <= '0;
      mc_cnt_q       <= '0;
      stall_cycles_q <= '0;
    end else begin
      pending_q      <= pending_d;
      mc_cnt_q       <= mc_cnt_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign bus.issue_o        = issue;
  assign bus.stall_o        = stall;
  assign bus.mc_busy_o      = (mc_cnt_q != 4'd0);
  assign bus.pending_o      = pending_q;
  assign bus.stall_cycles_o = stall_cycles_q;
endmodule
